// File: rtl/fetch_seq.sv
// fetch_seq: fetch-stage sequencer.
//   Drives next-PC into an external PC register and reads its current PC.
//   Issues instruction-memory reads using a req/ack handshake.
//   Presents {instruction, PC+4} to the IF/ID latch, backed by a one-entry skid.
//   Handles branch redirects. A redirect that arrives while a read is outstanding
//   is parked in DRAIN until the memory acks.
// Optional feature: define FETCH_TIMEOUT_EN to add a wait-cycle watchdog.
//   When an outstanding read waits MAX_WAIT cycles, the watchdog sets the sticky
//   fetch_err flag and parks the block in ERR until reset.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, ERR = 2'd3} state_t;
  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
`else
  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic        take_ack;     // ack data is a live instruction this cycle
  logic [31:0] pc_plus4;

`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fetch_err_q, fetch_err_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^MAX_WAIT;
`endif

  // The read address is always the PC register; 32-bit wrap is natural.
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Next-state, next-PC, request and output-slot decisions.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can infer a latch.
    state_d      = state_q;
    npc          = pc;
    imem_req     = 1'b0;
    take_ack     = 1'b0;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc4_d     = if_pc4_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    br_pend_d    = br_pend_q;
    tgt_d        = tgt_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    fetch_err_d  = fetch_err_q;
`endif

    case (state_q)
      BOOT: begin
        npc     = RESET_PC;
        state_d = FETCH;
      end
      FETCH: begin
        // A full skid blocks new requests. Once raised, the request holds until
        // ack because only an ack can fill the skid.
        imem_req = !skid_valid_q;
        if (br_taken) begin
          if (imem_req && !imem_ack) begin
            // Outstanding read: the memory must finish it before the redirect.
            br_pend_d = 1'b1;
            tgt_d     = br_target;
            state_d   = DRAIN;
          end else begin
            npc = br_target;
          end
        end else if (imem_req && imem_ack && !br_pend_q) begin
          npc      = pc_plus4;
          take_ack = 1'b1;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (br_taken) tgt_d = br_target;   // newest redirect wins
        if (imem_ack) begin
          npc       = br_taken ? br_target : tgt_q;
          br_pend_d = 1'b0;
          state_d   = FETCH;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ERR: begin
        npc = pc;
      end
`endif
      default: state_d = BOOT;
    endcase

    // Output slot and skid. A redirect flushes both, ignoring stall.
    if (br_taken) begin
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (if_valid_q && stall) begin
      if (take_ack) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc4_d   = pc_plus4;
      end
    end else if (skid_valid_q) begin
      if_valid_d   = 1'b1;
      if_instr_d   = skid_instr_q;
      if_pc4_d     = skid_pc4_q;
      skid_valid_d = 1'b0;
    end else if (take_ack) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_rdata;
      if_pc4_d   = pc_plus4;
    end else begin
      if_valid_d = 1'b0;
    end

`ifdef FETCH_TIMEOUT_EN
    // Watchdog. The count restarts at every ack, so each request begins from zero.
    if (imem_req && !imem_ack) begin
      if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
        fetch_err_d = 1'b1;
        wait_cnt_d  = '0;
        state_d     = ERR;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end else begin
      wait_cnt_d = '0;
    end
    if (state_q == ERR) begin
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc4_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      br_pend_q    <= 1'b0;
      tgt_q        <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q   <= '0;
      fetch_err_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc4_q     <= if_pc4_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      br_pend_q    <= br_pend_d;
      tgt_q        <= tgt_d;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      fetch_err_q  <= fetch_err_d;
`endif
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc4   = if_pc4_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule
